// File: rtl/cacheline_burst_adaptor_if.sv
// Bundle of the cache-side line port and the memory-side burst port.
// "slave" is the adaptor's view; "master" is the environment's view
// (cache requester plus memory responder).
interface cacheline_burst_adaptor_if #(
  parameter int s_beat = 64,
  parameter int s_line = 256
);
  logic [31:0]       line_address;
  logic              line_read;
  logic              line_write;
  logic [s_line-1:0] line_wdata;
  logic [s_line-1:0] line_rdata;
  logic              line_resp;
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  line_address, line_read, line_write, line_wdata,
    output line_rdata, line_resp,
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output line_address, line_read, line_write, line_wdata,
    input  line_rdata, line_resp,
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one whole-line cache read/write into a num_beats x s_beat
// memory burst. One transaction in flight; a single-cycle line_resp
// marks completion. The line buffer doubles as write-data source and
// read-data assembly register, and drives line_rdata at all times.
module cacheline_burst_adaptor #(
  parameter int s_beat    = 64,
  parameter int s_line    = 256,
  parameter int num_beats = 4,
  parameter int s_offset  = 5
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adaptor_if.slave bus
);

  localparam int CNT_W = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(num_beats - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_p0;
  state_t            state_nx;
  logic [31:0]       addr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [s_line-1:0] line_buf_p0;
  logic              last_beat;

  // A beat handshake that completes the line.
  assign last_beat = bus.burst_resp && (cnt_p0 == LAST_BEAT);

  // State register; reset abandons any in-flight burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nx;
    end
  end

  // Next-state logic; write wins if both requests are asserted.
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE: begin
        if (bus.line_write) begin
          state_nx = WRITE;
        end else if (bus.line_read) begin
          state_nx = READ;
        end
      end
      READ:    if (last_beat) state_nx = DONE;
      WRITE:   if (last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs decoded straight from the state register.
  always_comb begin
    bus.burst_read  = 1'b0;
    bus.burst_write = 1'b0;
    bus.line_resp   = 1'b0;
    case (state_p0)
      READ:    bus.burst_read  = 1'b1;
      WRITE:   bus.burst_write = 1'b1;
      DONE:    bus.line_resp   = 1'b1;
      default: ;
    endcase
  end

  // Address latch, beat counter and line buffer; burst_resp is only
  // honoured while a burst is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p0     <= '0;
      cnt_p0      <= '0;
      line_buf_p0 <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (bus.line_write) begin
            addr_p0     <= bus.line_address;
            line_buf_p0 <= bus.line_wdata;
          end else if (bus.line_read) begin
            addr_p0 <= bus.line_address;
          end
        end
        READ: begin
          if (bus.burst_resp) begin
            line_buf_p0[cnt_p0*s_beat +: s_beat] <= bus.burst_rdata;
            cnt_p0 <= last_beat ? '0 : cnt_p0 + CNT_W'(1);
          end
        end
        WRITE: begin
          if (bus.burst_resp) begin
            cnt_p0 <= last_beat ? '0 : cnt_p0 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.burst_address = addr_p0 & ADDR_MASK;
  assign bus.burst_wdata   = line_buf_p0[cnt_p0*s_beat +: s_beat];
  assign bus.line_rdata    = line_buf_p0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: the bench plays both the cache
// (line requests) and main memory (beat responses with gaps). Expected
// lines, addresses and completion cycles come from a transaction-level
// model: line = beats concatenated little-endian, address = line-aligned,
// completion = cycle after the last accepted beat.
module tb_cacheline_burst_adaptor;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cacheline_burst_adaptor_if #(.s_beat(64), .s_line(256)) bus ();

  cacheline_burst_adaptor #(
    .s_beat(64), .s_line(256), .num_beats(4), .s_offset(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  // mask bit (c-1) = memory responds in cycle c; mask 0 = random gaps.
  // data is the line to write, or the memory contents for a read.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] data, input logic [31:0] mask);
    int beats;
    int c;
    int exp_done;
    int seen;
    bit r;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    exp_done = 0;
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i] && seen < 4) begin
        seen++;
        if (seen == 4) exp_done = i + 2;
      end
    end
    bus.line_address = addr;
    bus.line_write   = wr;
    bus.line_read    = rd;
    bus.line_wdata   = wr ? data : rand_line();
    bus.burst_resp   = 1'b0;
    @(negedge clk);
    beats = 0;
    c = 1;
    while (beats < 4 && c < 60) begin
      chk("burst_read", {255'b0, bus.burst_read}, {255'b0, !wr});
      chk("burst_write", {255'b0, bus.burst_write}, {255'b0, wr});
      chk("burst_address", {224'b0, bus.burst_address}, {224'b0, exp_addr});
      chk("line_resp_busy", {255'b0, bus.line_resp}, 256'b0);
      if (wr) chk("burst_wdata", {192'b0, bus.burst_wdata}, {192'b0, data[beats*64 +: 64]});
      r = (mask != 0) ? ((c <= 32) ? mask[c-1] : 1'b1) : ($urandom_range(0, 3) != 0);
      bus.burst_resp  = r;
      bus.burst_rdata = (r && !wr) ? data[beats*64 +: 64] : {$urandom, $urandom};
      if (r) beats++;
      @(negedge clk);
      c++;
    end
    chk("beats_accepted", beats, 4);
    // DONE cycle: burst_resp here must be ignored.
    bus.burst_resp  = $urandom_range(0, 1);
    bus.burst_rdata = {$urandom, $urandom};
    if (mask != 0) chk("done_cycle", c, exp_done);
    chk("line_resp_done", {255'b0, bus.line_resp}, {255'b0, 1'b1});
    chk("burst_rd_done", {255'b0, bus.burst_read}, 256'b0);
    chk("burst_wr_done", {255'b0, bus.burst_write}, 256'b0);
    chk("line_rdata", bus.line_rdata, data);
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    @(negedge clk);
    bus.burst_resp = 1'b0;
    chk("line_resp_pulse", {255'b0, bus.line_resp}, 256'b0);
    chk("idle_no_burst", {254'b0, bus.burst_read, bus.burst_write}, 256'b0);
    chk("line_rdata_hold", bus.line_rdata, data);
  endtask

  logic [255:0] line_a;
  logic [255:0] line_b;

  initial begin
    rst = 1'b0;
    bus.line_address = '0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line_resp", {255'b0, bus.line_resp}, 256'b0);
    chk("rst_bursts", {254'b0, bus.burst_read, bus.burst_write}, 256'b0);
    chk("rst_address", {224'b0, bus.burst_address}, 256'b0);
    chk("rst_wdata", {192'b0, bus.burst_wdata}, 256'b0);
    chk("rst_rdata", bus.line_rdata, 256'b0);
    rst = 1'b1;
    @(negedge clk);

    // Directed read, consecutive beats.
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b0, 1'b1, 32'h0000_1234, line_a, 32'h0000_000F);

    // Directed write of byte pattern 0x00..0x1F.
    for (int i = 0; i < 32; i++) line_b[i*8 +: 8] = 8'(i);
    run_txn(1'b1, 1'b0, 32'h8000_00E0, line_b, 32'h0000_000F);

    // Read with gaps: beats in cycles 1, 3, 4, 7.
    line_a = rand_line();
    run_txn(1'b0, 1'b1, 32'h1234_5678, line_a, 32'h0000_004D);

    // Stray burst_resp while idle must not touch the buffer.
    for (int i = 0; i < 4; i++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk("stray_rdata", bus.line_rdata, line_a);
      chk("stray_resp", {255'b0, bus.line_resp}, 256'b0);
      chk("stray_bursts", {254'b0, bus.burst_read, bus.burst_write}, 256'b0);
    end
    bus.burst_resp = 1'b0;
    line_b = rand_line();
    run_txn(1'b0, 1'b1, 32'h0BAD_F00D, line_b, 32'h0000_000F);

    // Both requests high: write has priority.
    line_a = rand_line();
    run_txn(1'b1, 1'b1, 32'hCAFE_0040, line_a, 32'h0000_000F);

    // Reset in the middle of a read after two beats.
    bus.line_address = 32'h0000_2000;
    bus.line_read    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.burst_resp = 1'b0;
    #2 rst = 1'b0;
    bus.line_read = 1'b0;
    #1;
    chk("mid_rst_burst_read", {255'b0, bus.burst_read}, 256'b0);
    chk("mid_rst_line_resp", {255'b0, bus.line_resp}, 256'b0);
    chk("mid_rst_rdata", bus.line_rdata, 256'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_resp", {255'b0, bus.line_resp}, 256'b0);
    line_b = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_2000, line_b, 32'h0000_000F);

    // Randomized transactions with random gaps.
    for (int n = 0; n < 24; n++) begin
      bit w;
      w = $urandom_range(0, 1);
      run_txn(w, !w, $urandom, rand_line(), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the cache's 256-bit physical-memory line interface (`line_*`).
- Accepts one whole-line read or write from the cache.
- Converts it into a 4-beat, 64-bit burst on the main-memory interface (`burst_*`).
- Returns the assembled line with a single-cycle completion pulse.
- Sits between the cache datapath/control and the main memory model; one outstanding transaction at a time.

Parameters:
- s_beat, 64, beat width in bits.
- s_line, 256, line width in bits; must equal num_beats*s_beat.
- num_beats, 4, beats per line burst.
- s_offset, 5, line-offset bits cleared on the outgoing address.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- line_address  input  32  cache line address.
- line_read  input  1  line read request, held until line_resp.
- line_write  input  1  line write request, held until line_resp.
- line_wdata  input  s_line  line write data.
- line_rdata  output  s_line  assembled read line.
- line_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  line-aligned memory address.
- burst_read  output  1  memory read burst request.
- burst_write  output  1  memory write burst request.
- burst_wdata  output  s_beat  current write beat.
- burst_rdata  input  s_beat  incoming read beat.
- burst_resp  input  1  beat handshake: one beat transferred per cycle high.

Behaviour:
- Reset (rst low, any time, asynchronous): state IDLE, beat counter 0, line buffer 0, all outputs 0. An in-flight memory burst is abandoned; no line_resp is produced for it.
- States:
  - IDLE: on a clk edge with line_write=1, latch line_address and line_wdata, go to WRITE. Else if line_read=1, latch line_address, go to READ. line_write has priority if both are asserted (illegal per protocol).
  - READ:
    - burst_read=1; burst_address={latched_addr[31:s_offset], s_offset'b0}.
    - Each cycle burst_resp=1: buffer[cnt*s_beat +: s_beat] <= burst_rdata; cnt++.
    - Beats are little-endian: beat 0 = bits 63:0.
    - Gaps (burst_resp=0) are allowed and hold state.
    - On the num_beats-th beat: cnt<=0, go to DONE.
  - WRITE:
    - burst_write=1; same aligned address; burst_wdata=buffer[cnt*s_beat +: s_beat].
    - Each burst_resp=1 counts one accepted beat, cnt++.
    - On the num_beats-th accepted beat: cnt<=0, go to DONE.
  - DONE: line_resp=1 for exactly this cycle; burst_read=burst_write=0; next state IDLE unconditionally. The request still asserted during DONE is not re-sampled.
- line_rdata is driven from the buffer at all times. Valid in the DONE cycle of a read; held until the next transaction overwrites the buffer. After a write, line_rdata shows the written line.
- burst_address, burst_read and burst_write are registered/state-decoded, glitch-free, and constant for the whole burst.
- burst_resp in IDLE or DONE is ignored: no counter or buffer change.
- Counter width is clog2(num_beats); it never wraps past num_beats-1.
- Latency, request sampled at edge 0:
  - burst_read/write high from cycle 1.
  - With back-to-back beats in cycles 1..4, line_resp is high in cycle 5.
  - Minimum request-to-response is num_beats+1 cycles.
- Back-to-back: a new request may be sampled in the IDLE cycle immediately after DONE, giving a minimum of 1 idle cycle between bursts.

Test Plan:
- Reset mid-READ after 2 beats -> burst_read=0 and line_resp=0 immediately; after release a fresh read completes with correct data and stale beats are not used.
- Read at 0x0000_1234, memory returns beats 0x1111..11, 0x2222..22, 0x3333..33, 0x4444..44 on consecutive cycles -> burst_address=0x0000_1220; line_resp in cycle 5; line_rdata={0x4444..44, 0x3333..33, 0x2222..22, 0x1111..11}.
- Write of line 0x00..1F byte pattern at 0x8000_00E0, memory acks every cycle -> burst_wdata sequence 0x0706050403020100, 0x0F0E..08, 0x1716..10, 0x1F1E..18; line_resp in cycle 5.
- Read with burst_resp gaps (beats at cycles 1, 3, 4, 7) -> data captured only on resp cycles; line_resp in cycle 8; burst_read held constant throughout.
- Stray burst_resp=1 while IDLE, then a read -> buffer untouched before the read; read result correct; exactly one line_resp pulse.
- line_read and line_write both high in IDLE -> write burst issued (burst_write=1, burst_read=0), completing in 5 cycles; next request sampled only after the one-cycle DONE.
